// File: rtl/mem_writeback_pkg.sv
// Shared types for the memory writeback stage: op/size codes, S1 payload and writeback entry.
package mem_writeback_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        OP_ALU   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef struct packed {
        op_e              op;
        logic [REG_W-1:0] rd;
        size_e            size;
        logic             is_unsigned;
        logic [1:0]       addr_lo;
        logic [XLEN-1:0]  alu;
    } s1_entry_t;

    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/mem_writeback_if.sv
// Upstream operation, memory read data and register-file writeback signals of the stage.
interface mem_writeback_if;
    import mem_writeback_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [REG_W-1:0] in_rd;
    logic [1:0]       in_size;
    logic             in_unsigned;
    logic [1:0]       in_addr_lo;
    logic [XLEN-1:0]  in_alu;
    logic [XLEN-1:0]  mem_q;
    logic             wb_valid;
    logic             wb_ready;
    logic             wb_we;
    logic [REG_W-1:0] wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             misalign;

    modport slave (
        input  in_valid, in_op, in_rd, in_size, in_unsigned, in_addr_lo, in_alu, mem_q, wb_ready,
        output in_ready, wb_valid, wb_we, wb_rd, wb_data, misalign
    );

    modport master (
        output in_valid, in_op, in_rd, in_size, in_unsigned, in_addr_lo, in_alu, mem_q, wb_ready,
        input  in_ready, wb_valid, wb_we, wb_rd, wb_data, misalign
    );

endinterface

// File: rtl/mem_writeback_load_align.sv
// Little-endian lane select and sign/zero extension of a load word, with misalignment detect.
module load_align
    import mem_writeback_pkg::*;
(
    input  logic [XLEN-1:0] mem_q_i,
    input  size_e           size_i,
    input  logic            unsigned_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o,
    output logic            misalign_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c     = mem_q_i[{addr_lo_i, 3'b000} +: 8];
        half_c     = addr_lo_i[1] ? mem_q_i[31:16] : mem_q_i[15:0];
        data_o     = mem_q_i;
        misalign_o = 1'b0;
        unique case (size_i)
            SZ_BYTE: data_o = unsigned_i ? {24'h0, byte_c} : {{24{byte_c[7]}}, byte_c};
            SZ_HALF: begin
                data_o     = unsigned_i ? {16'h0, half_c} : {{16{half_c[15]}}, half_c};
                misalign_o = addr_lo_i[0];
            end
            // word and the reserved size code both take the full word
            default: misalign_o = (addr_lo_i != 2'd0);
        endcase
    end

endmodule

// File: rtl/mem_writeback.sv
// Writeback stage: one S1 register feeding a 2-entry in-order output buffer toward the register file.
module mem_writeback
    import mem_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_writeback_if.slave bus
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned OCC_W = CNT_W + 1;

    s1_entry_t         s1_q, s1_d;
    logic              s1_valid_q, s1_valid_d;
    wb_entry_t         fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              misalign_q, misalign_d;
    logic              accept_c, pop_c, push_c, is_load_c, wb_valid_c, ld_mis_c;
    logic [OCC_W-1:0]  occ_c;
    logic [XLEN-1:0]   ld_data_c;
    wb_entry_t         push_entry_c, head_c;

    // Occupancy after this cycle's pop decides whether a new op fits; wb_ready feeds in_ready directly.
    assign wb_valid_c   = (count_q != '0);
    assign pop_c        = wb_valid_c && bus.wb_ready;
    assign occ_c        = OCC_W'(count_q) + OCC_W'(s1_valid_q) - OCC_W'(pop_c);
    assign bus.in_ready = (occ_c <= OCC_W'(DEPTH - 1));
    assign accept_c     = bus.in_valid && bus.in_ready;

    load_align u_load_align (
        .mem_q_i    (bus.mem_q),
        .size_i     (s1_q.size),
        .unsigned_i (s1_q.is_unsigned),
        .addr_lo_i  (s1_q.addr_lo),
        .data_o     (ld_data_c),
        .misalign_o (ld_mis_c)
    );

    // Retire S1: stores vanish, ALU and LOAD produce one buffer entry.
    always_comb begin
        is_load_c         = (s1_q.op == OP_LOAD);
        push_c            = s1_valid_q && ((s1_q.op == OP_ALU) || is_load_c);
        push_entry_c.rd   = s1_q.rd;
        push_entry_c.data = s1_q.alu;
        push_entry_c.we   = (s1_q.rd != '0);
        misalign_d        = 1'b0;
        if (is_load_c) begin
            push_entry_c.data = ld_mis_c ? '0 : ld_data_c;
            push_entry_c.we   = (s1_q.rd != '0) && !ld_mis_c;
            misalign_d        = s1_valid_q && ld_mis_c;
        end
    end

    always_comb begin
        s1_valid_d = accept_c;
        s1_d       = s1_q;
        if (accept_c) begin
            s1_d = '{op:          op_e'(bus.in_op),
                     rd:          bus.in_rd,
                     size:        size_e'(bus.in_size),
                     is_unsigned: bus.in_unsigned,
                     addr_lo:     bus.in_addr_lo,
                     alu:         bus.in_alu};
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            count_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            misalign_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
            if (push_c) begin
                fifo_q[wr_ptr_q] <= push_entry_c;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // A push into a full buffer without a pop would lose an entry.
    always_ff @(posedge clk) begin
        if (rst && push_c && !pop_c) begin
            assert (count_q < CNT_W'(DEPTH));
        end
    end

    assign head_c       = fifo_q[rd_ptr_q];
    assign bus.wb_valid = wb_valid_c;
    assign bus.wb_we    = wb_valid_c && head_c.we;
    assign bus.wb_rd    = head_c.rd;
    assign bus.wb_data  = head_c.data;
    assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_mem_writeback.sv
// Self-checking bench for mem_writeback: directed scenarios plus a randomized run against a queue model.
module tb_mem_writeback;

    typedef struct {
        bit        we;
        bit [4:0]  rd;
        bit [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    mem_writeback_if bus();

    mem_writeback #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t model_q[$];
    bit   s1_busy, s1_push, mis_pend, exp_mis;
    bit   acc, ready_seen, valid_seen, popped, mis_after;
    logic        pop_we;
    logic [4:0]  pop_rd;
    logic [31:0] pop_data;

    // Expected writeback entry of one op, straight from the op/size/extension rules.
    function automatic void model_op(input logic [1:0] op, input logic [4:0] rd, input logic [1:0] sz,
                                     input bit uns, input logic [1:0] al, input logic [31:0] alu,
                                     input logic [31:0] memw, output bit push, output exp_t e, output bit mis);
        bit [31:0] v;
        push   = (op == 2'd0) || (op == 2'd1);
        mis    = 1'b0;
        e.rd   = rd;
        e.data = alu;
        if (op == 2'd1) begin
            if (sz == 2'd0) begin
                v = (memw >> (8 * int'(al))) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFFFF00;
            end else if (sz == 2'd1) begin
                mis = al[0];
                v   = (memw >> (16 * int'(al[1]))) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF0000;
            end else begin
                mis = (al != 2'd0);
                v   = memw;
            end
            e.data = mis ? 32'd0 : v;
        end
        e.we = (rd != 5'd0) && !mis;
    endfunction

    task automatic set_idle();
        bus.in_valid    = 1'b0;
        bus.in_op       = 2'd0;
        bus.in_rd       = 5'd0;
        bus.in_size     = 2'd0;
        bus.in_unsigned = 1'b0;
        bus.in_addr_lo  = 2'd0;
        bus.in_alu      = 32'd0;
        bus.mem_q       = 32'd0;
        bus.wb_ready    = 1'b1;
    endtask

    task automatic clear_model();
        model_q.delete();
        s1_busy  = 1'b0;
        s1_push  = 1'b0;
        mis_pend = 1'b0;
    endtask

    // One clock from negedge to negedge: drive, observe pre-edge outputs, then supply mem_q for an accepted load.
    task automatic cycle(input bit v, input logic [1:0] op, input logic [4:0] rd, input logic [1:0] sz,
                         input bit uns, input logic [1:0] al, input logic [31:0] alu,
                         input logic [31:0] memw, input bit rdy);
        exp_t e;
        bit   push, mis;
        bus.in_valid    = v;
        bus.in_op       = op;
        bus.in_rd       = rd;
        bus.in_size     = sz;
        bus.in_unsigned = uns;
        bus.in_addr_lo  = al;
        bus.in_alu      = alu;
        bus.wb_ready    = rdy;
        #1;
        ready_seen = bus.in_ready;
        acc        = v && bus.in_ready;
        valid_seen = bus.wb_valid;
        popped     = bus.wb_valid && rdy;
        pop_we     = bus.wb_we;
        pop_rd     = bus.wb_rd;
        pop_data   = bus.wb_data;
        model_op(op, rd, sz, uns, al, alu, memw, push, e, mis);
        exp_mis  = mis_pend;
        mis_pend = acc && (op == 2'd1) && mis;
        s1_busy  = acc;
        s1_push  = acc && push;
        if (acc && push) model_q.push_back(e);
        @(posedge clk);
        #1;
        bus.mem_q = (acc && op == 2'd1) ? memw : 32'($urandom);
        mis_after = bus.misalign;
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 2'd0, 5'd0, 2'd0, 1'b0, 2'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_model();
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #2;
        n_tests++;
        if ({bus.wb_valid, bus.wb_we, bus.misalign, bus.in_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_flags: valid/we/misalign/ready=%b, expected 0001",
                     {bus.wb_valid, bus.wb_we, bus.misalign, bus.in_ready});
        end
        n_tests++;
        if (bus.wb_rd !== 5'd0 || bus.wb_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: rd=%0d data=%h, expected rd=0 data=0", bus.wb_rd, bus.wb_data);
        end
        do_reset();
    endtask

    task automatic test_load_byte();
        cycle(1'b1, 2'd1, 5'd5, 2'd0, 1'b0, 2'd3, 32'd0, 32'h80112233, 1'b1);
        n_tests++;
        if (acc !== 1'b1) begin
            n_fail++;
            $display("FAIL first_accept: accepted=%0b, expected 1", acc);
        end
        idle(1'b1);
        n_tests++;
        if (valid_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_latency: wb_valid=%0b one cycle after accept, expected 0", valid_seen);
        end
        idle(1'b1);
        n_tests++;
        if (!popped || pop_we !== 1'b1 || pop_rd !== 5'd5 || pop_data !== 32'hFFFFFF80) begin
            n_fail++;
            $display("FAIL load_byte_signed: valid=%0b we=%0b rd=%0d data=%h, expected 1 1 5 ffffff80",
                     popped, pop_we, pop_rd, pop_data);
        end
        cycle(1'b1, 2'd1, 5'd6, 2'd0, 1'b1, 2'd1, 32'd0, 32'h00008000, 1'b1);
        idle(1'b1);
        idle(1'b1);
        n_tests++;
        if (!popped || pop_data !== 32'h00000080 || pop_rd !== 5'd6) begin
            n_fail++;
            $display("FAIL load_byte_unsigned: valid=%0b rd=%0d data=%h, expected 1 6 00000080",
                     popped, pop_rd, pop_data);
        end
    endtask

    task automatic test_load_half();
        cycle(1'b1, 2'd1, 5'd7, 2'd1, 1'b1, 2'd2, 32'd0, 32'hBEEF0000, 1'b1);
        idle(1'b1);
        idle(1'b1);
        n_tests++;
        if (!popped || pop_we !== 1'b1 || pop_data !== 32'h0000BEEF) begin
            n_fail++;
            $display("FAIL load_half_unsigned: valid=%0b we=%0b data=%h, expected 1 1 0000beef",
                     popped, pop_we, pop_data);
        end
        cycle(1'b1, 2'd1, 5'd7, 2'd1, 1'b1, 2'd1, 32'd0, 32'hBEEF0000, 1'b1);
        idle(1'b1);
        n_tests++;
        if (mis_after !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_pulse: misalign=%0b, expected 1", mis_after);
        end
        idle(1'b1);
        n_tests++;
        if (!popped || pop_we !== 1'b0 || pop_data !== 32'd0 || mis_after !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_entry: valid=%0b we=%0b data=%h misalign=%0b, expected 1 0 0 0",
                     popped, pop_we, pop_data, mis_after);
        end
        cycle(1'b1, 2'd1, 5'd8, 2'd1, 1'b0, 2'd0, 32'd0, 32'h00008001, 1'b1);
        idle(1'b1);
        idle(1'b1);
        n_tests++;
        if (!popped || pop_data !== 32'hFFFF8001) begin
            n_fail++;
            $display("FAIL load_half_signed: data=%h, expected ffff8001", pop_data);
        end
        cycle(1'b1, 2'd1, 5'd9, 2'd2, 1'b0, 2'd2, 32'd0, 32'h12345678, 1'b1);
        idle(1'b1);
        idle(1'b1);
        n_tests++;
        if (!popped || pop_we !== 1'b0 || pop_data !== 32'd0) begin
            n_fail++;
            $display("FAIL word_misalign: we=%0b data=%h, expected 0 0", pop_we, pop_data);
        end
    endtask

    task automatic test_alu_store();
        bit any_valid;
        cycle(1'b1, 2'd0, 5'd0, 2'd0, 1'b0, 2'd0, 32'h1234, 32'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        n_tests++;
        if (!popped || pop_we !== 1'b0 || pop_rd !== 5'd0 || pop_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL alu_rd0: valid=%0b we=%0b rd=%0d data=%h, expected 1 0 0 00001234",
                     popped, pop_we, pop_rd, pop_data);
        end
        any_valid = 1'b0;
        cycle(1'b1, 2'd2, 5'd3, 2'd2, 1'b0, 2'd0, 32'hAAAA, 32'd0, 1'b1);
        cycle(1'b1, 2'd3, 5'd4, 2'd2, 1'b0, 2'd0, 32'hBBBB, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            any_valid = any_valid | valid_seen;
        end
        n_tests++;
        if (any_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_dropped: wb_valid seen=%0b, expected 0", any_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        for (int i = 0; i < 4; i++) vals[i] = $urandom;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) cycle(1'b1, 2'd0, 5'(c + 1), 2'd2, 1'b0, 2'd0, vals[c], 32'd0, 1'b1);
            else       idle(1'b1);
            if (c < 4) begin
                n_tests++;
                if (acc !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready[%0d]: accepted=%0b, expected 1", c, acc);
                end
            end
            n_tests++;
            if (c < 2) begin
                if (popped !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_early[%0d]: wb_valid=%0b, expected 0", c, popped);
                end
            end else if (!popped || pop_rd !== 5'(c - 1) || pop_data !== vals[c - 2] || pop_we !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: valid=%0b rd=%0d data=%h, expected 1 %0d %h",
                         c, popped, pop_rd, pop_data, c - 1, vals[c - 2]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] vals [3];
        bit   [4:0]  acc_log;
        for (int i = 0; i < 3; i++) vals[i] = $urandom;
        cycle(1'b1, 2'd0, 5'd11, 2'd0, 1'b0, 2'd0, vals[0], 32'd0, 1'b0);
        acc_log[0] = acc;
        cycle(1'b1, 2'd0, 5'd12, 2'd0, 1'b0, 2'd0, vals[1], 32'd0, 1'b0);
        acc_log[1] = acc;
        cycle(1'b1, 2'd0, 5'd13, 2'd0, 1'b0, 2'd0, vals[2], 32'd0, 1'b0);
        acc_log[2] = acc;
        cycle(1'b1, 2'd0, 5'd13, 2'd0, 1'b0, 2'd0, vals[2], 32'd0, 1'b0);
        acc_log[3] = acc;
        cycle(1'b1, 2'd0, 5'd13, 2'd0, 1'b0, 2'd0, vals[2], 32'd0, 1'b1);
        acc_log[4] = acc;
        n_tests++;
        if (acc_log !== 5'b10011) begin
            n_fail++;
            $display("FAIL bp_accepts: accept pattern (newest first)=%b, expected 10011", acc_log);
        end
        n_tests++;
        if (!popped || pop_rd !== 5'd11 || pop_data !== vals[0]) begin
            n_fail++;
            $display("FAIL bp_drain0: valid=%0b rd=%0d data=%h, expected 1 11 %h", popped, pop_rd, pop_data, vals[0]);
        end
        for (int i = 1; i < 3; i++) begin
            idle(1'b1);
            n_tests++;
            if (!popped || pop_rd !== 5'(11 + i) || pop_data !== vals[i]) begin
                n_fail++;
                $display("FAIL bp_drain%0d: valid=%0b rd=%0d data=%h, expected 1 %0d %h",
                         i, popped, pop_rd, pop_data, 11 + i, vals[i]);
            end
        end
        idle(1'b1);
        n_tests++;
        if (valid_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: wb_valid=%0b, expected 0", valid_seen);
        end
    endtask

    task automatic test_reset_mid();
        bit stale;
        cycle(1'b1, 2'd0, 5'd1, 2'd0, 1'b0, 2'd0, 32'h111, 32'd0, 1'b0);
        cycle(1'b1, 2'd0, 5'd2, 2'd0, 1'b0, 2'd0, 32'h222, 32'd0, 1'b0);
        cycle(1'b1, 2'd0, 5'd3, 2'd0, 1'b0, 2'd0, 32'h333, 32'd0, 1'b0);
        n_tests++;
        if (bus.wb_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_before_reset: valid=%0b ready=%0b, expected 1 0", bus.wb_valid, bus.in_ready);
        end
        set_idle();
        bus.wb_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: valid=%0b ready=%0b, expected 0 1", bus.wb_valid, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        cycle(1'b1, 2'd1, 5'd9, 2'd2, 1'b0, 2'd0, 32'd0, 32'hCAFEF00D, 1'b1);
        #2;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        stale = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            stale = stale | valid_seen | mis_after;
        end
        n_tests++;
        if (stale !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_after_reset: output activity=%0b, expected 0", stale);
        end
        cycle(1'b1, 2'd0, 5'd4, 2'd0, 1'b0, 2'd0, 32'h4444, 32'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        n_tests++;
        if (!popped || pop_rd !== 5'd4 || pop_data !== 32'h4444) begin
            n_fail++;
            $display("FAIL post_reset_op: valid=%0b rd=%0d data=%h, expected 1 4 00004444", popped, pop_rd, pop_data);
        end
    endtask

    task automatic test_random();
        exp_t        e;
        bit          v, uns, rdy, exp_valid, exp_ready;
        logic [1:0]  op, sz, al;
        logic [4:0]  rd;
        logic [31:0] alu, memw;
        int          fifo_n;
        do_reset();
        for (int k = 0; k < 410; k++) begin
            v    = ($urandom_range(0, 3) != 0) && (k < 400);
            op   = 2'($urandom);
            rd   = 5'($urandom);
            sz   = 2'($urandom);
            uns  = 1'($urandom);
            al   = 2'($urandom);
            alu  = $urandom;
            memw = $urandom;
            rdy  = (k >= 400) || ($urandom_range(0, 3) != 0);
            fifo_n    = model_q.size() - int'(s1_push);
            exp_valid = (fifo_n > 0);
            exp_ready = (fifo_n + int'(s1_busy) - int'(exp_valid && rdy)) <= 1;
            cycle(v, op, rd, sz, uns, al, alu, memw, rdy);
            n_tests++;
            if (ready_seen !== exp_ready || valid_seen !== exp_valid) begin
                n_fail++;
                $display("FAIL rnd_flow[%0d]: ready=%0b valid=%0b, expected %0b %0b",
                         k, ready_seen, valid_seen, exp_ready, exp_valid);
            end
            if (popped) begin
                n_tests++;
                if (model_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_extra[%0d]: unexpected entry rd=%0d data=%h", k, pop_rd, pop_data);
                end else begin
                    e = model_q.pop_front();
                    if (pop_we !== e.we || pop_rd !== e.rd || pop_data !== e.data) begin
                        n_fail++;
                        $display("FAIL rnd_entry[%0d]: we=%0b rd=%0d data=%h, expected %0b %0d %h",
                                 k, pop_we, pop_rd, pop_data, e.we, e.rd, e.data);
                    end
                end
            end
            n_tests++;
            if (mis_after !== exp_mis) begin
                n_fail++;
                $display("FAIL rnd_misalign[%0d]: misalign=%0b, expected %0b", k, mis_after, exp_mis);
            end
        end
        n_tests++;
        if (model_q.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_lost: %0d entries never written back, expected 0", model_q.size());
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_byte();
        test_load_half();
        test_alu_store();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
